// File: rtl/gpio_irq_ctrl.sv
// gpio_irq_ctrl: latches GPIO interrupts into pending bits, masks them and raises one CPU irq
// with a lowest-index claim/holdoff handshake behind an APB slave port.
module gpio_irq_ctrl #(
    parameter int N_GPIO         = 32,
    parameter int APB_ADDR_WIDTH = 12,
    parameter int HOLDOFF_CYCLES = 4
) (
    input  logic                      HCLK,
    input  logic                      HRESETn,
    input  logic [APB_ADDR_WIDTH-1:0] PADDR,
    input  logic [31:0]               PWDATA,
    input  logic                      PWRITE,
    input  logic                      PSEL,
    input  logic                      PENABLE,
    output logic [31:0]               PRDATA,
    output logic                      PREADY,
    output logic                      PSLVERR,
    input  logic [N_GPIO-1:0]         gpio_int_i,
    output logic                      irq_o,
    output logic [5:0]                irq_id_o
);
    typedef enum logic [1:0] {IDLE = 2'd0, ASSERT = 2'd1, HOLDOFF = 2'd2} state_t;
    state_t state;
    logic [N_GPIO-1:0] pending, mask, active, clr, pending_n, mask_n;
    logic [63:0] pend_w, mask_w;
    logic [5:0] win;
    logic [6:0] n_active;
    logic [7:0] cnt;
    logic [11:0] off;
    logic any, any_n, rd, wr, claim, clear_wr;
    assign off      = PADDR[11:0];
    assign rd       = PSEL & PENABLE & ~PWRITE;
    assign wr       = PSEL & PENABLE & PWRITE;
    assign active   = pending & mask;
    assign any      = |active;
    assign claim    = rd && off == 12'h014 && any;
    assign clear_wr = wr && off == 12'h010;
    assign PREADY   = 1'b1;
    assign PSLVERR  = 1'b0;
    assign irq_o    = state == ASSERT;
    always_comb begin
        win      = '0;
        n_active = '0;
        pend_w   = '0;
        mask_w   = '0;
        pend_w[N_GPIO-1:0] = pending;
        mask_w[N_GPIO-1:0] = mask;
        for (int i = N_GPIO - 1; i >= 0; i--) begin
            if (active[i]) win = 6'(i);
            n_active = n_active + 7'(active[i]);
        end
    end
    // Out-of-range CLEAR indices simply match no bit; set beats clear on the same bit.
    always_comb begin
        clr    = '0;
        mask_n = mask;
        for (int i = 0; i < N_GPIO; i++) begin
            clr[i]    = (claim && win == 6'(i)) || (clear_wr && PWDATA[5:0] == 6'(i));
            mask_n[i] = (wr && off == (i < 32 ? 12'h008 : 12'h00C)) ? PWDATA[i % 32] : mask[i];
        end
    end
    assign pending_n = (pending & ~clr) | gpio_int_i;
    assign any_n     = |(pending_n & mask_n);
    always_comb begin
        PRDATA = '0;
        if (rd)
            case (off)
                12'h000: PRDATA = pend_w[31:0];
                12'h004: PRDATA = pend_w[63:32];
                12'h008: PRDATA = mask_w[31:0];
                12'h00C: PRDATA = mask_w[63:32];
                12'h014: PRDATA = {any, 25'd0, win};
                12'h018: PRDATA = {21'd0, state, irq_o, 1'b0, n_active};
                default: PRDATA = '0;
            endcase
    end
    // Holdoff leaves at cnt<=1 so that, with the IDLE cycle, irq_o stays low HOLDOFF_CYCLES cycles.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            pending  <= '0;
            mask     <= '0;
            state    <= IDLE;
            cnt      <= '0;
            irq_id_o <= '0;
        end else begin
            pending <= pending_n;
            mask    <= mask_n;
            if (any) irq_id_o <= win;
            case (state)
                IDLE: if (any) state <= ASSERT;
                ASSERT:
                    if (claim) begin
                        state <= HOLDOFF;
                        cnt   <= 8'(HOLDOFF_CYCLES - 1);
                    end else if (!any_n) state <= IDLE;
                HOLDOFF: begin
                    cnt <= cnt - 8'(cnt != 8'd0);
                    if (cnt <= 8'd1) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_gpio_irq_ctrl.sv
// tb_gpio_irq_ctrl: directed checks of pending/mask/claim/holdoff behaviour with N_GPIO=40.
module tb_gpio_irq_ctrl;
    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b0;
    logic [11:0] PADDR = '0;
    logic [31:0] PWDATA = '0;
    logic        PWRITE = 1'b0;
    logic        PSEL = 1'b0;
    logic        PENABLE = 1'b0;
    logic [31:0] PRDATA;
    logic        PREADY, PSLVERR;
    logic [39:0] gpio = '0;
    logic        irq_o;
    logic [5:0]  irq_id_o;
    logic [31:0] rdat;
    int checks = 0;
    int errors = 0;
    int ids[3] = '{3, 7, 12};

    gpio_irq_ctrl #(.N_GPIO(40), .APB_ADDR_WIDTH(12), .HOLDOFF_CYCLES(4)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE),
        .PSEL(PSEL), .PENABLE(PENABLE), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
        .gpio_int_i(gpio), .irq_o(irq_o), .irq_id_o(irq_id_o)
    );

    always #5 HCLK = ~HCLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic apb_write(input logic [11:0] a, input logic [31:0] d);
        tick();
        PSEL = 1'b1; PWRITE = 1'b1; PADDR = a; PWDATA = d; PENABLE = 1'b0;
        tick();
        PENABLE = 1'b1;
        tick();
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic apb_read(input logic [11:0] a, output logic [31:0] d);
        tick();
        PSEL = 1'b1; PWRITE = 1'b0; PADDR = a; PENABLE = 1'b0;
        tick();
        PENABLE = 1'b1;
        #1 d = PRDATA;
        tick();
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    task automatic pulse(input logic [39:0] v);
        tick();
        gpio = v;
        tick();
        gpio = '0;
    endtask

    initial begin
        #2;
        chk("rst_irq", 32'(irq_o), 32'd0);
        chk("rst_id", 32'(irq_id_o), 32'd0);
        chk("rst_prdata", PRDATA, 32'd0);
        chk("pready", 32'(PREADY), 32'd1);
        repeat (2) tick();
        HRESETn = 1'b1;

        pulse(40'h20);
        apb_read(12'h000, rdat);
        chk("pend0_masked", rdat, 32'h20);
        chk("irq_masked", 32'(irq_o), 32'd0);
        apb_write(12'h008, 32'h20);
        chk("irq_mask_lat1", 32'(irq_o), 32'd0);
        tick();
        chk("irq_mask_lat2", 32'(irq_o), 32'd1);
        chk("id_5", 32'(irq_id_o), 32'd5);
        apb_read(12'h014, rdat);
        chk("claim_5", rdat, 32'h80000005);
        repeat (8) tick();

        apb_write(12'h008, 32'hFFFF_FFFF);
        pulse(40'h1088);
        tick();
        chk("irq_multi", 32'(irq_o), 32'd1);
        chk("id_3", 32'(irq_id_o), 32'd3);
        apb_read(12'h018, rdat);
        chk("stat_3act", rdat, 32'h303);
        for (int k = 0; k < 3; k++) begin
            apb_read(12'h014, rdat);
            chk($sformatf("claim_%0d", ids[k]), rdat, 32'h80000000 | 32'(ids[k]));
            for (int c = 0; c < 4; c++) begin
                chk($sformatf("holdoff_%0d_c%0d", ids[k], c), 32'(irq_o), 32'd0);
                tick();
            end
            chk($sformatf("rearm_after_%0d", ids[k]), 32'(irq_o), k < 2 ? 32'd1 : 32'd0);
            if (k < 2) chk($sformatf("id_after_%0d", ids[k]), 32'(irq_id_o), 32'(ids[k + 1]));
        end
        apb_read(12'h014, rdat);
        chk("claim_empty", rdat, 32'h0);
        chk("irq_empty", 32'(irq_o), 32'd0);

        tick();
        gpio[2] = 1'b1;
        tick();
        tick();
        chk("irq_level", 32'(irq_o), 32'd1);
        chk("id_2", 32'(irq_id_o), 32'd2);
        apb_read(12'h014, rdat);
        chk("claim_2", rdat, 32'h80000002);
        apb_read(12'h000, rdat);
        chk("pend_set_wins", rdat, 32'h4);
        chk("level_idle", 32'(irq_o), 32'd0);
        tick();
        chk("level_reassert", 32'(irq_o), 32'd1);
        gpio[2] = 1'b0;
        apb_read(12'h014, rdat);
        chk("claim_2b", rdat, 32'h80000002);
        repeat (8) tick();
        apb_read(12'h000, rdat);
        chk("pend_after_level", rdat, 32'h0);
        chk("irq_after_level", 32'(irq_o), 32'd0);

        pulse(40'h200);
        tick();
        chk("irq_9", 32'(irq_o), 32'd1);
        apb_write(12'h010, 32'd9);
        chk("clear_idle", 32'(irq_o), 32'd0);
        apb_read(12'h018, rdat);
        chk("stat_empty", rdat, 32'h0);

        apb_write(12'h00C, 32'h8);
        pulse(40'h08_0000_0000);
        apb_read(12'h004, rdat);
        chk("pend1_35", rdat, 32'h8);
        chk("id_35", 32'(irq_id_o), 32'd35);
        apb_read(12'h014, rdat);
        chk("claim_35", rdat, 32'h80000023);
        repeat (8) tick();
        apb_write(12'h00C, 32'hFFFF_FFFF);
        apb_read(12'h00C, rdat);
        chk("mask1_width", rdat, 32'hFF);
        pulse(40'h80_0000_0000);
        apb_read(12'h004, rdat);
        chk("pend1_39", rdat, 32'h80);
        apb_write(12'h010, 32'd50);
        apb_read(12'h004, rdat);
        chk("clear_50_noop", rdat, 32'h80);
        apb_write(12'h010, 32'd39);
        apb_read(12'h004, rdat);
        chk("clear_39", rdat, 32'h0);
        apb_read(12'h01C, rdat);
        chk("unmapped", rdat, 32'h0);
        chk("prdata_idle", PRDATA, 32'h0);

        pulse(40'h12);
        tick();
        apb_read(12'h014, rdat);
        chk("claim_1", rdat, 32'h80000002 - 32'd1);
        HRESETn = 1'b0;
        #1;
        chk("rst_mid_irq", 32'(irq_o), 32'd0);
        chk("rst_mid_id", 32'(irq_id_o), 32'd0);
        chk("rst_mid_prdata", PRDATA, 32'd0);
        repeat (2) tick();
        HRESETn = 1'b1;
        apb_read(12'h000, rdat);
        chk("rst_pend0", rdat, 32'h0);
        apb_read(12'h008, rdat);
        chk("rst_mask0", rdat, 32'h0);
        chk("rst_irq_after", 32'(irq_o), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/gpio_irq_ctrl.md
Name: gpio_irq_ctrl

Overview:
Interrupt aggregation stage directly downstream of the APB GPIO block. It consumes the per-pin interrupt vector, latches it into pending bits and applies a per-pin mask. It selects the lowest-index active source and drives a single CPU-facing irq line with a claim/holdoff handshake. Software reads status and claims or clears sources through its own APB slave port.

Parameters:
N_GPIO, 32, number of GPIO interrupt sources; legal range 1..64.
APB_ADDR_WIDTH, 12, APB address width.
HOLDOFF_CYCLES, 4, minimum irq_o low cycles after a claim; legal range 1..255.

Ports:
HCLK  in  1  clock
HRESETn  in  1  reset, asynchronous, active-low
PADDR  in  APB_ADDR_WIDTH  APB address; decode uses PADDR[11:0]
PWDATA  in  32  APB write data
PWRITE  in  1  APB write strobe
PSEL  in  1  APB select
PENABLE  in  1  APB enable
PRDATA  out  32  APB read data
PREADY  out  1  tied 1
PSLVERR  out  1  tied 0
gpio_int_i  in  N_GPIO  per-pin interrupt from the GPIO block; may be a single-cycle pulse (edge types) or a held level
irq_o  out  1  aggregated interrupt to the CPU
irq_id_o  out  6  index of the current winning source

Behaviour:
- Access cycle = PSEL & PENABLE. All register side effects occur at the HCLK edge that ends the access cycle. Zero wait states.
- Register map (byte offsets):
  - 0x000 PEND0 RO: pending[31:0].
  - 0x004 PEND1 RO: pending[63:32].
  - 0x008 MASK0 RW: mask[31:0]; 1 = source enabled.
  - 0x00C MASK1 RW: mask[63:32].
  - 0x010 CLEAR WO: PWDATA[5:0] is the pin index; clears that pending bit.
  - 0x014 CLAIM RO: {31=valid, 30:6=0, 5:0=id}; returns the winning source and clears its pending bit.
  - 0x018 STAT RO: [6:0]=count of pending&mask, [8]=irq_o, [10:9]=FSM state.
- Register bits at or above N_GPIO read 0 and ignore writes. CLEAR with an index >= N_GPIO has no effect. Unmapped offsets read 0 and ignore writes.
- PRDATA is combinational, valid only during a read access cycle; 0 at all other times.
- Pending logic:
  - pending[i] is set on every cycle that gpio_int_i[i] = 1, independent of mask.
  - When a set and a clear (CLEAR or CLAIM) hit the same bit in the same cycle, set wins. A held level therefore re-pends immediately after being cleared.
- Winner selection:
  - active = pending & mask.
  - Winner = lowest set index in active.
  - irq_id_o is registered: it updates every cycle to the winner and holds its last value when active = 0.
- CLAIM read:
  - If active != 0: returns valid=1 and id = current winner (combinational, same-cycle value); clears pending[id] at the end of the access cycle.
  - If active = 0: returns valid=0, id=0; no state change.
- FSM (registered; irq_o is a decoded output):
  - IDLE (irq_o=0): go to ASSERT when active != 0.
  - ASSERT (irq_o=1): on a CLAIM read with valid=1, go to HOLDOFF and load cnt = HOLDOFF_CYCLES-1. If active falls to 0 via CLEAR or mask writes, go to IDLE.
  - HOLDOFF (irq_o=0): decrement cnt each cycle; when cnt = 0, go to IDLE. Still-active sources re-raise irq_o on the following cycle.
- Latency:
  - gpio_int_i pulse at cycle N: pending set at N+1; IDLE->ASSERT seen at N+2, so irq_o = 1 at N+2.
  - irq_id_o is also valid at N+2.
- MASK writes take effect on active the cycle after the write. Masking does not clear pending.
- Reset (async): pending=0, mask=0, FSM=IDLE, cnt=0, irq_o=0, irq_id_o=0. PRDATA is 0 because it is combinational.
- Reset mid-HOLDOFF or mid-access discards all state. The first cycle after release behaves as a fresh reset state.

Test Plan:
- Reset, mask=0: pulse gpio_int_i[5] -> PEND0=0x20, irq_o stays 0. Write MASK0=0x20 -> irq_o=1 two cycles later, irq_id_o=5.
- MASK0=0xFFFFFFFF; pulse pins 3, 7 and 12 in the same cycle -> claim sequence returns 0x80000003, 0x80000007, 0x8000000C, then 0x00000000. irq_o is low for exactly 4 cycles after each valid claim.
- Hold gpio_int_i[2]=1 and CLAIM -> pending[2] remains 1 (set wins), and irq_o reasserts after the holdoff.
- CLEAR write of 9 while pin 9 is the only active source -> FSM returns to IDLE, irq_o=0 next cycle, STAT[6:0]=0.
- N_GPIO=40: pulse pin 35, MASK1=0x8 -> PEND1=0x8, CLAIM returns 0x80000023. CLEAR of 50 has no effect. A PEND1 read never shows bits >= 8.
- Assert HRESETn low during HOLDOFF with pins pending -> all outputs 0 immediately. After release, PEND0 reads 0 and irq_o stays 0.
